uart_tx: RTL and testbench

Serial UART transmitter. It is the transmit-side counterpart of `Uart_Rx` in the low-power communication system. It accepts a parallel byte with a one-cycle valid strobe and serialises it as start bit, 8 data bits LSB first, optional even/odd parity, and stop bit. Each bit is held for `Prescale` clock cycles, so a `Uart_Rx` on the same clock and `Prescale` receives the frame directly in loopback.

---
 rtl/uart_tx.sv | 89 ++++++++
 tb/tb_uart_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serialises a latched byte as start, LSB-first data, optional parity and stop bits,
// each bit held for Prescale cycles (a Prescale of 0 behaves as 1).
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_valid,
  input  logic                  Parity_EN,
  input  logic                  Parity_type,
  input  logic [4:0]            Prescale,
  output logic                  S_Data,
  output logic                  busy
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d, pre_q, pre_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pen_q, pen_d, pty_q, pty_d, s_q, s_d, busy_q, busy_d;
  logic                  last;
  // a latched prescale of 0 ends every bit after one cycle
  assign last = (pre_q == 5'd0) || (cnt_q == pre_q - 5'd1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pen_d   = pen_q;
    pty_d   = pty_q;
    pre_d   = pre_q;
    if (state_q == IDLE) begin
      if (Data_valid) begin
        state_d = START;
        data_d  = P_Data;
        pen_d   = Parity_EN;
        pty_d   = Parity_type;
        pre_d   = Prescale;
        cnt_d   = 5'd0;
        bit_d   = '0;
      end
    end else begin
      cnt_d = last ? 5'd0 : cnt_q + 5'd1;
      if (last) begin
        case (state_q)
          START:   state_d = DATA;
          DATA: begin
            bit_d = bit_q + 1'b1;
            if (bit_q == BW'(DATA_WIDTH - 1)) state_d = pen_q ? PARITY : STOP;
          end
          PARITY:  state_d = STOP;
          default: state_d = IDLE;
        endcase
      end
    end
    // output is registered from the next state so the line moves only at bit boundaries
    s_d    = state_d == START  ? 1'b0 :
             state_d == DATA   ? data_d[bit_d] :
             state_d == PARITY ? (^data_q) ^ pty_q : 1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      bit_q   <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      pty_q   <= 1'b0;
      pre_q   <= 5'd0;
      s_q     <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      pty_q   <= pty_d;
      pre_q   <= pre_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
    end
  end
  assign S_Data = s_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed frames checked cycle-by-cycle against a queue-based
// line model, plus a bench-side receiver that decodes the serial line back into bytes.
module tb_uart_tx;
  logic       CLK = 1'b0, Reset, Data_valid = 1'b0, Parity_EN = 1'b0, Parity_type = 1'b0;
  logic [7:0] P_Data = 8'h00;
  logic [4:0] Prescale = 5'd8;
  logic       S_Data, busy;
  int         checks = 0, fails = 0, rst_cnt = 0, len;
  logic       chk_on = 1'b0;
  logic       trace[$];

  always #10 CLK = ~CLK;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .Reset(Reset), .P_Data(P_Data), .Data_valid(Data_valid),
    .Parity_EN(Parity_EN), .Parity_type(Parity_type), .Prescale(Prescale),
    .S_Data(S_Data), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line model: each accepted frame expands into one expected S_Data value per clock.
  typedef struct {logic [7:0] d; logic pen; logic pt; int p;} desc_t;
  logic  exp_q[$];
  desc_t dq[$];
  logic  eb = 1'b0, es = 1'b1;

  function automatic logic par(input logic [7:0] d, input logic pt);
    return (^d) ^ pt;
  endfunction

  function automatic void push_frame(input logic [7:0] d, input logic pen, input logic pt,
                                     input logic [4:0] pre);
    int   p = (pre == 5'd0) ? 1 : int'(pre);
    logic b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pen) b.push_back(par(d, pt));
    b.push_back(1'b1);
    foreach (b[i]) for (int r = 0; r < p; r++) exp_q.push_back(b[i]);
    dq.push_back('{d, pen, pt, p});
  endfunction

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      exp_q.delete();
      dq.delete();
      eb <= 1'b0;
      es <= 1'b1;
    end else begin
      if (!eb && Data_valid) push_frame(P_Data, Parity_EN, Parity_type, Prescale);
      if (exp_q.size() > 0) begin
        es <= exp_q.pop_front();
        eb <= 1'b1;
      end else begin
        es <= 1'b1;
        eb <= 1'b0;
      end
    end
  end

  always @(posedge Reset) rst_cnt++;

  always @(negedge CLK) begin
    if (chk_on) begin
      check("s_data_cycle", S_Data, es);
      check("busy_cycle", busy, eb);
    end
  end

  // Receiver: samples the first cycle of every bit and checks byte, parity and stop.
  task automatic rx_frame();
    desc_t      f = dq.pop_front();
    int         rc = rst_cnt;
    logic [7:0] d;
    logic       pb = 1'b0, sb;
    for (int i = 0; i < 8; i++) begin
      repeat (f.p) @(negedge CLK);
      if (rst_cnt != rc) return;
      d[i] = S_Data;
    end
    if (f.pen) begin
      repeat (f.p) @(negedge CLK);
      if (rst_cnt != rc) return;
      pb = S_Data;
    end
    repeat (f.p) @(negedge CLK);
    if (rst_cnt != rc) return;
    sb = S_Data;
    check("rx_data", d, f.d);
    if (f.pen) check("rx_parity", pb, par(f.d, f.pt));
    check("rx_stop", sb, 1'b1);
  endtask

  initial forever begin
    @(negedge CLK);
    if (!Reset && S_Data === 1'b0 && dq.size() > 0) rx_frame();
  end

  // Starts a frame from a negedge, then traces S_Data until busy drops; optional mid-frame pulse.
  task automatic run(input logic [7:0] d, input logic pen, input logic pt, input logic [4:0] pre,
                     input int pulse_at);
    P_Data = d; Parity_EN = pen; Parity_type = pt; Prescale = pre; Data_valid = 1'b1;
    @(negedge CLK);
    Data_valid = 1'b0;
    trace.delete();
    len = 0;
    while (busy === 1'b1 && len < 3000) begin
      trace.push_back(S_Data);
      if (len == pulse_at) begin
        P_Data = 8'h00; Parity_EN = !pen; Parity_type = !pt; Prescale = 5'd4; Data_valid = 1'b1;
      end else Data_valid = 1'b0;
      len++;
      @(negedge CLK);
    end
    Data_valid = 1'b0;
    if (len >= 3000) check("busy_timeout", len, 0);
  endtask

  initial begin
    logic [10:0] f_d5, f_a3;
    logic [9:0]  f_ff;
    int          n, p;
    f_d5 = 11'b1_1_11010101_0;
    f_a3 = 11'b1_0_10100011_0;
    f_ff = 10'b1_11111111_0;
    Reset = 1'b1;
    #35;
    check("reset_s_data", S_Data, 1'b1);
    check("reset_busy", busy, 1'b0);
    @(negedge CLK);
    Reset = 1'b0;
    chk_on = 1'b1;
    @(negedge CLK);
    run(8'hD5, 1'b1, 1'b0, 5'd8, -1);
    check("d5_len", len, 88);
    for (int i = 0; i < 11; i++) check("d5_bit", trace[i*8+4], f_d5[i]);
    run(8'h55, 1'b1, 1'b1, 5'd8, -1);
    check("55_odd_len", len, 88);
    check("55_odd_parity", trace[76], 1'b1);
    run(8'h55, 1'b1, 1'b0, 5'd8, -1);
    check("55_even_len", len, 88);
    check("55_even_parity", trace[76], 1'b0);
    run(8'hFF, 1'b0, 1'b0, 5'd8, -1);
    check("ff_len", len, 80);
    for (int i = 0; i < 10; i++) check("ff_bit", trace[i*8+4], f_ff[i]);
    run(8'hD5, 1'b1, 1'b0, 5'd8, 20);
    check("midchg_len", len, 88);
    for (int i = 0; i < 11; i++) check("midchg_bit", trace[i*8+4], f_d5[i]);
    run(P_Data, Parity_EN, Parity_type, Prescale, -1);
    check("newcfg_len", len, 40);
    check("newcfg_start", trace[2], 1'b0);
    check("newcfg_data", trace[18], 1'b0);
    P_Data = 8'h3C; Parity_EN = 1'b1; Parity_type = 1'b0; Prescale = 5'd8; Data_valid = 1'b1;
    @(negedge CLK);
    Data_valid = 1'b0;
    repeat (36) @(negedge CLK);
    #3 Reset = 1'b1;
    #1;
    check("async_rst_s_data", S_Data, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    run(8'hA3, 1'b1, 1'b0, 5'd8, -1);
    check("a3_len", len, 88);
    for (int i = 0; i < 11; i++) check("a3_bit", trace[i*8+4], f_a3[i]);
    for (int k = 0; k < 3; k++) begin
      p = (k == 0) ? 8 : (k == 1) ? 1 : 0;
      run(8'hD5, 1'b1, 1'b0, 5'(p), -1);
      check("loop_len", len, 11 * ((p == 0) ? 1 : p));
      run(8'hF5, 1'b1, 1'b0, 5'(p), -1);
      run(8'hD0, 1'b1, 1'b0, 5'(p), -1);
    end
    check("p0_len", len, 11);
    repeat (40) begin
      logic [7:0] d;
      logic       pen, pt;
      logic [4:0] pre;
      d = 8'($urandom);
      pen = 1'($urandom);
      pt = 1'($urandom);
      pre = 5'($urandom_range(0, 9));
      n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1;
      run(d, pen, pt, pre, n);
      check("rand_len", len, (pen ? 11 : 10) * ((pre == 5'd0) ? 1 : int'(pre)));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    repeat (3) @(negedge CLK);
    check("model_drained", exp_q.size(), 0);
    check("rx_drained", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
